// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART transmit arbiter.
// Contents: arbiter state enum, N_REQ / BUSY_TIMEOUT defaults, byte type,
// and the widths of the grant index and internal counters.
package uart_arb_pkg;

  localparam int unsigned N_REQ_DEF        = 3;
  localparam int unsigned BUSY_TIMEOUT_DEF = 16;
  localparam int unsigned ID_W             = 3;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned TXCNT_W          = 16;
  localparam int unsigned BYTE_W           = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tx_grant_pick.sv
// tx_grant_pick: combinational winner select among byte requesters.
// Ports:
//   i_req_valid  in   N_REQ  requesters with a byte pending
//   i_ptr        in   3      index of the last winner (round-robin origin)
//   o_grant      out  N_REQ  one-hot winner, zero when nothing is pending
//   o_grant_id   out  3      index of the winner
// Macro UART_ARB_ROUND_ROBIN_EN: defined selects round-robin starting after
// i_ptr; undefined selects fixed priority (lowest index wins, i_ptr ignored).
module tx_grant_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id
);

`ifdef UART_ARB_ROUND_ROBIN_EN
  int unsigned w_dist;
  int unsigned w_best;

  // Distance of requester k from the slot after i_ptr; smallest pending wins.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_best     = N_REQ;
    w_dist     = 0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_dist = 32'(k) + N_REQ - 32'(i_ptr) - 32'd1;
      if (w_dist >= N_REQ) begin
        w_dist = w_dist - N_REQ;
      end
      if (i_req_valid[k] && (w_dist < w_best)) begin
        w_best     = w_dist;
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_grant_id = ID_W'(k);
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Scan from the top down so the lowest pending index is the last write.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_grant_id = ID_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte requesters.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[N]      requester i has a byte ready (held until accepted)
//   req_byte[8N]      byte of requester i in bits [8i+7:8i]
//   req_ready[N]      combinational one-hot accept for the winner
//   is_transmitting   UART busy flag
//   transmit          one-cycle UART load strobe
//   tx_byte[8]        byte presented to the UART
//   grant_id[3]       index of the last accepted requester
//   tx_drop           one-cycle pulse when busy fails to rise in time
//   tx_count[16]      bytes the UART confirmed starting (wraps)
// Macro UART_ARB_ROUND_ROBIN_EN: defined builds round-robin arbitration with a
// last-winner pointer; undefined builds fixed priority with no pointer.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_byte,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 is_transmitting,
  output logic                 transmit,
  output logic [BYTE_W-1:0]    tx_byte,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tx_drop,
  output logic [TXCNT_W-1:0]   tx_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  PTR_RESET    = ID_W'(N_REQ - 1);

  arb_state_e           r_state;
  logic [CNT_W-1:0]     r_busy_cnt;
  logic                 r_transmit;
  logic                 r_tx_drop;
  byte_t                r_tx_byte;
  logic [ID_W-1:0]      r_grant_id;
  logic [TXCNT_W-1:0]   r_tx_count;

  logic [ID_W-1:0]      w_ptr;
  logic [N_REQ-1:0]     w_grant;
  logic [ID_W-1:0]      w_grant_id;
  logic                 w_accept_ok;
  logic                 w_xfer;
  byte_t                w_sel_byte;

  tx_grant_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req_valid (req_valid),
    .i_ptr       (w_ptr),
    .o_grant     (w_grant),
    .o_grant_id  (w_grant_id)
  );

  // Accept only in IDLE with the UART free; rst_n gates it during reset.
  assign w_accept_ok = rst_n && (r_state == ST_IDLE) && !is_transmitting;
  assign req_ready   = w_accept_ok ? w_grant : '0;
  assign w_xfer      = |(req_valid & req_ready);

  // Byte of the one-hot winner.
  always_comb begin
    w_sel_byte = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (w_grant[k]) begin
        w_sel_byte = req_byte[8*k +: 8];
      end
    end
  end

`ifdef UART_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;

  // Last-winner pointer; moves only when a byte is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PTR_RESET;
    end else if (w_xfer) begin
      r_ptr <= w_grant_id;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = PTR_RESET;
`endif

  // Arbiter FSM with registered strobes, byte, grant index and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy_cnt <= '0;
      r_transmit <= 1'b0;
      r_tx_drop  <= 1'b0;
      r_tx_byte  <= '0;
      r_grant_id <= '0;
      r_tx_count <= '0;
    end else begin
      r_transmit <= 1'b0;
      r_tx_drop  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_tx_byte  <= w_sel_byte;
            r_grant_id <= w_grant_id;
            r_transmit <= 1'b1;
            r_busy_cnt <= '0;
            r_state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          // Busy is tested first so a rise on the timeout cycle still counts.
          if (is_transmitting) begin
            r_tx_count <= r_tx_count + TXCNT_W'(1);
            r_state    <= ST_WAIT_DONE;
          end else if (r_busy_cnt == TIMEOUT_LAST) begin
            r_tx_drop  <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_busy_cnt <= r_busy_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!is_transmitting) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign transmit = r_transmit;
  assign tx_drop  = r_tx_drop;
  assign tx_byte  = r_tx_byte;
  assign grant_id = r_grant_id;
  assign tx_count = r_tx_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a grant/byte
// scoreboard and a reference arbitration model. Follows the same
// UART_ARB_ROUND_ROBIN_EN macro as the design to choose the expected winner.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]  req_ready;
  logic          is_transmitting;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic [2:0]    grant_id;
  logic          tx_drop;
  logic [15:0]   tx_count;

  int            n_tests;
  int            n_fail;
  logic [10:0]   sb_q[$];
  int            mptr;
  logic [15:0]   mcount;
  logic [2:0]    mgid;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_byte        (req_byte),
    .req_ready       (req_ready),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .grant_id        (grant_id),
    .tx_drop         (tx_drop),
    .tx_count        (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [2:0] v);
`ifdef UART_ARB_ROUND_ROBIN_EN
    for (int off = 1; off <= N; off++) begin
      if (v[(mptr + off) % N]) return (mptr + off) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (v[k]) return k;
    end
`endif
    return 0;
  endfunction

  // One arbitrated byte. dly<0: UART never goes busy (timeout path);
  // otherwise busy rises dly cycles after the transmit cycle for len cycles.
  task automatic do_xfer(input logic [2:0] valid, input logic [23:0] bytes,
                         input int dly, input int len, input string tag);
    int          id;
    logic [10:0] exp_e;
    req_valid = valid;
    req_byte  = bytes;
    #1;
    id = model_pick(valid);
    sb_q.push_back({3'(id), 8'(bytes >> (8 * id))});
    mptr = id;
    mgid = 3'(id);
    chk({tag, ".ready"}, 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    exp_e = sb_q.pop_front();
    chk({tag, ".transmit"}, 32'(transmit), 32'd1);
    chk({tag, ".tx_byte"},  32'(tx_byte),  32'(exp_e[7:0]));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(exp_e[10:8]));
    if (dly < 0) begin
      for (int i = 1; i < TO; i++) @(negedge clk);
      chk({tag, ".drop_early"}, 32'(tx_drop), 32'd0);
      chk({tag, ".ready_wait"}, 32'(req_ready), 32'd0);
      req_valid = '0;
      @(negedge clk);
      chk({tag, ".drop"},     32'(tx_drop),  32'd1);
      chk({tag, ".count"},    32'(tx_count), 32'(mcount));
      @(negedge clk);
      chk({tag, ".drop_end"}, 32'(tx_drop),  32'd0);
    end else begin
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        chk({tag, ".drop_wb"}, 32'(tx_drop), 32'd0);
      end
      is_transmitting = 1'b1;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        chk({tag, ".drop_wd"},  32'(tx_drop),   32'd0);
        chk({tag, ".ready_wd"}, 32'(req_ready), 32'd0);
      end
      req_valid       = '0;
      is_transmitting = 1'b0;
      mcount          = mcount + 16'd1;
      @(negedge clk);
      chk({tag, ".count"},    32'(tx_count), 32'(mcount));
      chk({tag, ".tx_low"},   32'(transmit), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mptr    = N - 1;
    mcount  = 16'd0;
    mgid    = 3'd0;
    rst_n           = 1'b0;
    req_valid       = 3'b111;
    req_byte        = 24'hA5A5A5;
    is_transmitting = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready",    32'(req_ready), 32'd0);
    chk("rst.transmit", 32'(transmit),  32'd0);
    chk("rst.drop",     32'(tx_drop),   32'd0);
    chk("rst.tx_byte",  32'(tx_byte),   32'd0);
    chk("rst.grant_id", 32'(grant_id),  32'd0);
    chk("rst.count",    32'(tx_count),  32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Six bytes with all requesters pending: 0,1,2,0,1,2 or always 0.
    for (int i = 0; i < 6; i++) begin
      do_xfer(3'b111, {8'(8'hC0 + i), 8'(8'hB0 + i), 8'(8'hA0 + i)}, 1, 3, "all3");
    end

    // Single request, busy 2 cycles after transmit for 10 cycles.
    do_xfer(3'b001, 24'h00005A, 2, 10, "single");

    // Fastest turnaround: busy on the transmit cycle for one cycle.
    do_xfer(3'b001, 24'h000011, 0, 1, "b2b_a");
    do_xfer(3'b001, 24'h000022, 0, 1, "b2b_b");

    // Busy never rises: drop after BUSY_TIMEOUT, then a normal byte.
    do_xfer(3'b010, 24'h003300, -1, 0, "timeout");
    do_xfer(3'b100, 24'h440000, 3, 2, "after_to");

    // Busy rises exactly on the timeout cycle: busy wins.
    do_xfer(3'b001, 24'h000055, TO - 1, 2, "tie");

    // UART busy at entry: no accept until it falls.
    is_transmitting = 1'b1;
    req_valid       = 3'b010;
    req_byte        = 24'h006600;
    @(negedge clk);
    chk("busy_in.ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("busy_in.ready1", 32'(req_ready), 32'd0);
    is_transmitting = 1'b0;
    do_xfer(3'b010, 24'h006600, 1, 2, "busy_in");

    // Requester withdraws while the UART is busy: nothing granted.
    is_transmitting = 1'b1;
    req_valid       = 3'b100;
    @(negedge clk);
    req_valid       = '0;
    is_transmitting = 1'b0;
    #1;
    chk("withdraw.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("withdraw.transmit", 32'(transmit), 32'd0);
    chk("withdraw.grant_id", 32'(grant_id), 32'(mgid));

    // Reset while in WAIT_DONE.
    req_valid = 3'b001;
    req_byte  = 24'h000077;
    @(negedge clk);
    chk("rst_mid.transmit", 32'(transmit), 32'd1);
    is_transmitting = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n           = 1'b0;
    is_transmitting = 1'b0;
    #1;
    chk("rst_mid.ready",    32'(req_ready), 32'd0);
    chk("rst_mid.transmit", 32'(transmit),  32'd0);
    chk("rst_mid.drop",     32'(tx_drop),   32'd0);
    chk("rst_mid.tx_byte",  32'(tx_byte),   32'd0);
    chk("rst_mid.grant_id", 32'(grant_id),  32'd0);
    chk("rst_mid.count",    32'(tx_count),  32'd0);
    @(negedge clk);
    chk("rst_mid.drop2",    32'(tx_drop),   32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    mptr      = N - 1;
    mcount    = 16'd0;
    @(negedge clk);

    // After reset requester 0 wins first.
    do_xfer(3'b111, 24'h9A8B7C, 1, 2, "post_rst");

    // Counter wrap from 0xFFFF.
    force dut.r_tx_count = 16'hFFFF;
    #1;
    release dut.r_tx_count;
    mcount = 16'hFFFF;
    @(negedge clk);
    chk("wrap.preload", 32'(tx_count), 32'h0000FFFF);
    do_xfer(3'b100, 24'hE10000, 1, 2, "wrap");
    chk("wrap.zero", 32'(tx_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of byte requesters sharing the UART transmitter, range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 16: cycles allowed for is_transmitting to rise after a transmit pulse, range 2..255.
REQ-003 Ports: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  master clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  N_REQ  requester i has a byte ready; held until accepted.
REQ-007 req_byte  input  8*N_REQ  byte of requester i in bits [8i+7:8i].
REQ-008 req_ready  output  N_REQ  one-hot; combinational accept for the winning requester.
REQ-009 is_transmitting  input  1  UART transmitter busy flag.
REQ-010 transmit  output  1  single-cycle UART load strobe.
REQ-011 tx_byte  output  8  byte presented to the UART; stable while transmit is high.
REQ-012 grant_id  output  3  index of the last accepted requester.
REQ-013 tx_drop  output  1  single-cycle pulse when a busy-rise timeout occurs.
REQ-014 tx_count  output  16  count of bytes confirmed started by the UART.

Function
REQ-015 States: IDLE, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE: req_ready is zero unless any req_valid is high and is_transmitting is low; then exactly one bit, for the winner, is high.
REQ-017 Handshake: a transfer occurs on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 On a transfer, the next edge does all of the following: registers req_byte[i] into tx_byte, sets grant_id to i, drives transmit high for one cycle and enters WAIT_BUSY.
REQ-019 Latency: transmit rises exactly one cycle after the handshake cycle.
REQ-020 WAIT_BUSY: req_ready is zero, and an 8-bit counter increments each cycle.
REQ-021 WAIT_BUSY exit on busy: if is_transmitting is high, enter WAIT_DONE and increment tx_count, wrapping from 0xFFFF to 0.
REQ-022 WAIT_BUSY exit on timeout: if the counter reaches BUSY_TIMEOUT-1 with is_transmitting still low, pulse tx_drop for one cycle and return to IDLE; tx_count does not change.
REQ-023 WAIT_BUSY tie: if is_transmitting rises on the same cycle as the timeout, busy wins and no drop is reported.
REQ-024 WAIT_DONE: req_ready is zero; return to IDLE on the first cycle is_transmitting is low.
REQ-025 Back-to-back rate: a new handshake is possible on the cycle after WAIT_DONE exits; the minimum gap between transmit pulses is therefore 3 cycles.
REQ-026 A requester that drops req_valid before it is accepted is simply not granted, and no error is flagged.
REQ-027 tx_byte holds its last value outside a transfer.

Reset
REQ-028 While rst_n is low, immediately: state IDLE, transmit 0, tx_drop 0, tx_byte 0x00, grant_id 0, tx_count 0, counter 0, and round-robin pointer N_REQ-1, so requester 0 wins first.
REQ-029 Reset asserted during WAIT_BUSY or WAIT_DONE abandons tracking with no tx_drop; a UART byte already in flight is not affected.
REQ-030 req_ready is 0 during reset.

Configuration
REQ-031 Macro UART_ARB_ROUND_ROBIN_EN defined selects round-robin arbitration.
REQ-032 Round-robin search order starts at the index after the last winner and wraps modulo N_REQ; the pointer updates only on a transfer.
REQ-033 Macro UART_ARB_ROUND_ROBIN_EN undefined selects fixed priority: the lowest asserted index wins; the pointer register is not built.

Structure
REQ-034 Package uart_arb_pkg holds the state enum, the defaults for N_REQ and BUSY_TIMEOUT, and the 8-bit byte type.
REQ-035 Sub-module tx_grant_pick is a purely combinational winner select, taking req_valid and the pointer and returning a one-hot grant plus its index; it includes both arbitration variants under the macro.
REQ-036 The FSM, counters and output registers live in uart_tx_arbiter.

Verification
REQ-037 Single request: req_valid=001, byte0=0x5A, UART raises busy 2 cycles after transmit and holds it 10 cycles -> req_ready=001 for 1 cycle, transmit 1 cycle later with tx_byte=0x5A, tx_count=1, return to IDLE.
REQ-038 Round-robin with macro: req_valid=111 held for 6 bytes -> grant_id sequence 0,1,2,0,1,2.
REQ-039 Fixed priority without macro: req_valid=111 held for 6 bytes -> grant_id always 0; requesters 1 and 2 are never granted.
REQ-040 Timeout: BUSY_TIMEOUT=16, busy never rises -> tx_drop pulses exactly 16 cycles after transmit, tx_count unchanged, next request accepted.
REQ-041 Busy at entry: is_transmitting=1 with req_valid=010 -> req_ready stays 0 until busy falls, then the grant occurs.
REQ-042 Reset mid-operation and wrap: assert rst_n=0 during WAIT_DONE -> all outputs at reset values and no tx_drop; preload tx_count to 0xFFFF and send 1 byte -> tx_count=0.
